// File: rtl/tilt_pkg.sv
// Shared direction codes and per-axis FSM state encoding for the tilt classifier.
package tilt_pkg;
  localparam logic [1:0] DIR_NEUTRAL = 2'b00;
  localparam logic [1:0] DIR_POS     = 2'b01;
  localparam logic [1:0] DIR_NEG     = 2'b10;

  // State encoding equals the output code so oDIR is a direct copy of the state.
  typedef enum logic [1:0] {
    ST_NEUTRAL = DIR_NEUTRAL,
    ST_POS     = DIR_POS,
    ST_NEG     = DIR_NEG
  } tilt_state_e;
endpackage

// File: rtl/tilt_axis.sv
// One accelerometer axis: inversion, hysteresis candidate, debounce and committed state.
module tilt_axis
  import tilt_pkg::*;
#(
  parameter int SAMPLE_W = 10,
  parameter int THRESH   = 64,
  parameter int HYST     = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iSAMPLE_VALID,
  input  logic [SAMPLE_W-1:0] iSAMPLE,
  input  logic                iINVERT,
  output logic [1:0]          oDIR,
  output logic                oCOMMIT,
  output logic                oNEUTRAL_NXT
);
  localparam int CW      = $clog2(DEBOUNCE + 1);
  localparam int EXIT_TH = THRESH - HYST;

  tilt_state_e       state_q, state_d, cand, pend_q, pend_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_run;
  logic              commit, chg_q;
  logic signed [SAMPLE_W:0] s_ext, s_eff;
  int                s_int;

  // One extra bit so negating the most negative sample stays representable.
  assign s_ext = $signed({iSAMPLE[SAMPLE_W-1], iSAMPLE});
  assign s_eff = iINVERT ? -s_ext : s_ext;
  assign s_int = int'(s_eff);

  always_comb begin
    cand = state_q;
    case (state_q)
      ST_NEUTRAL: begin
        if (s_int >= THRESH)       cand = ST_POS;
        else if (s_int <= -THRESH) cand = ST_NEG;
        else                       cand = ST_NEUTRAL;
      end
      ST_POS: begin
        if (s_int <= -THRESH)      cand = ST_NEG;
        else if (s_int < EXIT_TH)  cand = ST_NEUTRAL;
        else                       cand = ST_POS;
      end
      ST_NEG: begin
        if (s_int >= THRESH)       cand = ST_POS;
        else if (s_int > -EXIT_TH) cand = ST_NEUTRAL;
        else                       cand = ST_NEG;
      end
      default: cand = ST_NEUTRAL;
    endcase
  end

  assign cnt_run = (cand != pend_q) ? CW'(1) : cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    if (iSAMPLE_VALID) begin
      if (cand == state_q) begin
        cnt_d = '0;
      end else if (cnt_run == CW'(DEBOUNCE)) begin
        state_d = cand;
        pend_d  = cand;
        cnt_d   = '0;
        commit  = 1'b1;
      end else begin
        pend_d = cand;
        cnt_d  = cnt_run;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_NEUTRAL;
      pend_q  <= ST_NEUTRAL;
      cnt_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      chg_q   <= commit;
    end
  end

  assign oDIR         = state_q;
  assign oCOMMIT      = chg_q;
  assign oNEUTRAL_NXT = (state_d == ST_NEUTRAL);
endmodule

// File: rtl/tilt_classifier.sv
// Multi-axis tilt classifier: per-axis FSMs plus shared change pulse and at-rest detector.
module tilt_classifier
  import tilt_pkg::*;
#(
  parameter int NUM_AXES = 2,
  parameter int SAMPLE_W = 10,
  parameter int THRESH   = 64,
  parameter int HYST     = 16,
  parameter int DEBOUNCE = 4,
  parameter int STOP_N   = 8
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iSAMPLE_VALID,
  input  logic [NUM_AXES*SAMPLE_W-1:0] iSAMPLE,
  input  logic [NUM_AXES-1:0]          iINVERT,
  output logic [2*NUM_AXES-1:0]        oDIR,
  output logic                         oCHANGE,
  output logic                         oSTOP
);
  localparam int SW = $clog2(STOP_N + 1);

  logic [NUM_AXES-1:0] commit, neutral_nxt;
  logic [SW-1:0]       stop_q, stop_d;

  for (genvar k = 0; k < NUM_AXES; k++) begin : g_axis
    tilt_axis #(
      .SAMPLE_W (SAMPLE_W),
      .THRESH   (THRESH),
      .HYST     (HYST),
      .DEBOUNCE (DEBOUNCE)
    ) u_axis (
      .iCLK          (iCLK),
      .iRST          (iRST),
      .iSAMPLE_VALID (iSAMPLE_VALID),
      .iSAMPLE       (iSAMPLE[k*SAMPLE_W +: SAMPLE_W]),
      .iINVERT       (iINVERT[k]),
      .oDIR          (oDIR[2*k +: 2]),
      .oCOMMIT       (commit[k]),
      .oNEUTRAL_NXT  (neutral_nxt[k])
    );
  end

  // Uses post-update state so oSTOP falls in the same cycle the leaving commit shows.
  always_comb begin
    stop_d = stop_q;
    if (iSAMPLE_VALID) begin
      if (&neutral_nxt) stop_d = (stop_q == SW'(STOP_N)) ? stop_q : stop_q + SW'(1);
      else              stop_d = '0;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) stop_q <= '0;
    else      stop_q <= stop_d;
  end

  assign oCHANGE = |commit;
  assign oSTOP   = (stop_q == SW'(STOP_N));
endmodule

// File: tb/tb_tilt_classifier.sv
// Scoreboarded bench for tilt_classifier with directed scenarios and a random soak.
module tb_tilt_classifier;
  localparam int NA = 2, SWD = 10, TH = 64, HY = 16, DB = 4, SN = 8;

  logic                iCLK = 1'b0;
  logic                iRST = 1'b1;
  logic                iSAMPLE_VALID = 1'b0;
  logic [NA*SWD-1:0]   iSAMPLE = '0;
  logic [NA-1:0]       iINVERT = '0;
  logic [2*NA-1:0]     oDIR;
  logic                oCHANGE, oSTOP;

  tilt_classifier #(.NUM_AXES(NA), .SAMPLE_W(SWD), .THRESH(TH), .HYST(HY),
                    .DEBOUNCE(DB), .STOP_N(SN)) dut (
    .iCLK(iCLK), .iRST(iRST), .iSAMPLE_VALID(iSAMPLE_VALID), .iSAMPLE(iSAMPLE),
    .iINVERT(iINVERT), .oDIR(oDIR), .oCHANGE(oCHANGE), .oSTOP(oSTOP));

  always #5 iCLK = ~iCLK;

  typedef struct {
    int         due;
    logic [3:0] dir;
    logic       chg;
    logic       stop;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, cycn = 0;
  int   m_st[NA], m_cnt[NA], m_pend[NA], m_stop;

  always @(posedge iCLK) cycn <= cycn + 1;

  always @(negedge iCLK) begin
    if (sb.size() > 0 && sb[0].due == cycn) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (oDIR !== e.dir || oCHANGE !== e.chg || oSTOP !== e.stop) begin
        errors++;
        $display("FAIL scoreboard cyc %0d: got dir=%b chg=%b stop=%b want dir=%b chg=%b stop=%b",
                 cycn, oDIR, oCHANGE, oSTOP, e.dir, e.chg, e.stop);
      end
    end
  end

  // Reference model: 0 neutral, 1 pos, 2 neg.
  function automatic logic model_step(input bit rst, input bit v, input int x, input int y,
                                      input logic [1:0] inv);
    int s, c;
    logic chg = 1'b0;
    bit all_n = 1'b1;
    if (rst) begin
      for (int k = 0; k < NA; k++) begin m_st[k] = 0; m_cnt[k] = 0; m_pend[k] = 0; end
      m_stop = 0;
      return 1'b0;
    end
    if (!v) return 1'b0;
    for (int k = 0; k < NA; k++) begin
      s = (k == 0) ? x : y;
      if (inv[k]) s = -s;
      case (m_st[k])
        0: c = (s >= TH) ? 1 : (s <= -TH) ? 2 : 0;
        1: c = (s <= -TH) ? 2 : (s < TH - HY) ? 0 : 1;
        default: c = (s >= TH) ? 1 : (s > -(TH - HY)) ? 0 : 2;
      endcase
      if (c == m_st[k]) m_cnt[k] = 0;
      else begin
        if (c != m_pend[k]) m_cnt[k] = 1; else m_cnt[k]++;
        m_pend[k] = c;
        if (m_cnt[k] >= DB) begin m_st[k] = c; m_cnt[k] = 0; chg = 1'b1; end
      end
      if (m_st[k] != 0) all_n = 1'b0;
    end
    m_stop = all_n ? ((m_stop < SN) ? m_stop + 1 : SN) : 0;
    return chg;
  endfunction

  task automatic cyc(input bit rst, input bit v, input int x, input int y,
                     input logic [1:0] inv = 2'b00);
    exp_t e;
    @(negedge iCLK);
    iRST = rst; iSAMPLE_VALID = v; iINVERT = inv;
    iSAMPLE = {SWD'(y), SWD'(x)};
    e.chg  = model_step(rst, v, x, y, inv);
    e.due  = cycn + 1;
    e.dir  = {2'(m_st[1]), 2'(m_st[0])};
    e.stop = (m_stop == SN);
    sb.push_back(e);
  endtask

  task automatic settle;
    @(posedge iCLK); #1;
  endtask

  task automatic test_reset;
    cyc(1, 1, 100, 100);
    cyc(1, 0, 0, 0);
    settle();
    checks++;
    if (oDIR !== 4'b0 || oCHANGE !== 1'b0 || oSTOP !== 1'b0) begin
      errors++;
      $display("FAIL reset: got dir=%b chg=%b stop=%b want 0000/0/0", oDIR, oCHANGE, oSTOP);
    end
  endtask

  task automatic test_stop;
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0);
    settle();
    checks++;
    if (oSTOP !== 1'b0) begin errors++; $display("FAIL stop_early: got %b want 0", oSTOP); end
    cyc(0, 1, 0, 0);
    settle();
    checks++;
    if (oSTOP !== 1'b1) begin errors++; $display("FAIL stop_8th: got %b want 1", oSTOP); end
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0);
      cyc(0, 0, 300, 300);
      cyc(0, 1, 0, 0);
    end
    settle();
    checks++;
    if (oSTOP !== 1'b1) begin errors++; $display("FAIL stop_gaps: got %b want 1", oSTOP); end
  endtask

  task automatic test_commit;
    for (int i = 0; i < 3; i++) cyc(0, 1, 64, 0);
    settle();
    checks++;
    if (oDIR !== 4'b0000 || oSTOP !== 1'b1) begin
      errors++; $display("FAIL commit_pre: got dir=%b stop=%b want 0000/1", oDIR, oSTOP);
    end
    cyc(0, 1, 64, 0);
    settle();
    checks++;
    if (oDIR !== 4'b0001 || oCHANGE !== 1'b1 || oSTOP !== 1'b0) begin
      errors++; $display("FAIL commit_4th: got dir=%b chg=%b stop=%b want 0001/1/0", oDIR, oCHANGE, oSTOP);
    end
    cyc(0, 1, 64, 0);
    settle();
    checks++;
    if (oCHANGE !== 1'b0) begin errors++; $display("FAIL commit_pulse: got %b want 0", oCHANGE); end
  endtask

  task automatic test_hyst;
    for (int i = 0; i < 10; i++) cyc(0, 1, 50, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 47, 0);
    settle();
    checks++;
    if (oDIR !== 4'b0001) begin errors++; $display("FAIL hyst_hold: got %b want 0001", oDIR); end
    cyc(0, 1, 47, 0);
    settle();
    checks++;
    if (oDIR !== 4'b0000 || oCHANGE !== 1'b1) begin
      errors++; $display("FAIL hyst_exit: got dir=%b chg=%b want 0000/1", oDIR, oCHANGE);
    end
  endtask

  task automatic test_debounce_break;
    int seq[7] = '{70, 70, 70, 0, 70, 70, 70};
    foreach (seq[i]) cyc(0, 1, seq[i], 0);
    settle();
    checks++;
    if (oDIR !== 4'b0000) begin errors++; $display("FAIL db_break: got %b want 0000", oDIR); end
    cyc(0, 0, 0, 0);
    cyc(0, 1, 70, 0);
    settle();
    checks++;
    if (oDIR !== 4'b0001) begin errors++; $display("FAIL db_commit: got %b want 0001", oDIR); end
  endtask

  task automatic test_swing;
    for (int i = 0; i < 4; i++) cyc(0, 1, -64, -64);
    settle();
    checks++;
    if (oDIR !== 4'b1010 || oCHANGE !== 1'b1) begin
      errors++; $display("FAIL swing: got dir=%b chg=%b want 1010/1", oDIR, oCHANGE);
    end
    cyc(0, 1, -64, -64);
    settle();
    checks++;
    if (oCHANGE !== 1'b0) begin errors++; $display("FAIL swing_pulse: got %b want 0", oCHANGE); end
  endtask

  task automatic test_invert;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, -512, 0, 2'b01);
    settle();
    checks++;
    if (oDIR !== 4'b0001) begin errors++; $display("FAIL invert: got %b want 0001", oDIR); end
  endtask

  task automatic test_reset_mid;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 64, 0);
    cyc(1, 1, 64, 0);
    settle();
    checks++;
    if (oDIR !== 4'b0 || oCHANGE !== 1'b0 || oSTOP !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got dir=%b chg=%b stop=%b want 0000/0/0", oDIR, oCHANGE, oSTOP);
    end
    for (int i = 0; i < 3; i++) cyc(0, 1, 64, 0);
    settle();
    checks++;
    if (oDIR !== 4'b0000) begin errors++; $display("FAIL rst_partial: got %b want 0000", oDIR); end
    cyc(0, 1, 64, 0);
    settle();
    checks++;
    if (oDIR !== 4'b0001) begin errors++; $display("FAIL rst_recommit: got %b want 0001", oDIR); end
  endtask

  task automatic test_random;
    int x, y;
    for (int i = 0; i < 400; i++) begin
      x = int'($urandom_range(200)) - 100;
      y = int'($urandom_range(200)) - 100;
      if ($urandom_range(9) == 0) x = -512;
      cyc(0, $urandom_range(3) != 0, x, y, 2'($urandom_range(3)));
    end
  endtask

  initial begin
    test_reset();
    test_stop();
    test_commit();
    test_hyst();
    test_debounce_break();
    test_swing();
    test_invert();
    test_reset_mid();
    test_random();
    cyc(0, 0, 0, 0);
    repeat (3) @(negedge iCLK);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL drain: %0d left want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
